// File: rtl/cntr_pkg.sv
// Shared encodings for the up/down counter family.
// Direction and end-of-range mode enums reused by later counter variants.
package cntr_pkg;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } cntr_dir_e;

   typedef enum logic {
      END_WRAP = 1'b0,
      END_SAT  = 1'b1
   } cntr_end_e;

endpackage

// File: rtl/cntr_ud_mod.sv
// Programmable-modulus up/down counter with load, enable, wrap/saturate.
// Ports: clk, reset (sync, active-high), en, up_down, sat, load, load_val,
//        max_val -> bin_count, tc, at_max, at_min (all registered).
module cntr_ud_mod
   import cntr_pkg::*;
#(
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_down,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] bin_count,
   output logic             tc,
   output logic             at_max,
   output logic             at_min
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             at_max_q, at_max_d;
   logic             at_min_q, at_min_d;
   logic             rst_max, rst_min;
   cntr_dir_e        dir;
   cntr_end_e        mode;

   always_comb begin
      dir      = cntr_dir_e'(up_down);
      mode     = cntr_end_e'(sat);
      count_d  = count_q;
      tc_d     = 1'b0;
      if (load) begin
         count_d = (load_val > max_val) ? max_val : load_val;
      end else if (en) begin
         if (max_val == '0) begin
            // Single-value range: every step lands on the boundary.
            count_d = '0;
            tc_d    = 1'b1;
         end else if (dir == DIR_UP) begin
            if (count_q < max_val) begin
               count_d = count_q + WIDTH'(1);
            end else begin
               tc_d    = 1'b1;
               count_d = (mode == END_SAT) ? max_val : '0;
            end
         end else begin
            if (count_q == '0) begin
               tc_d    = 1'b1;
               count_d = (mode == END_SAT) ? '0 : max_val;
            end else if (count_q > max_val) begin
               // Range shrank below the count: pull back inside.
               count_d = max_val;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
      at_max_d = (count_d >= max_val);
      at_min_d = (count_d == '0);
      rst_max  = (RESET_VAL >= max_val);
      rst_min  = (RESET_VAL == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= RESET_VAL;
         tc_q     <= 1'b0;
         at_max_q <= rst_max;
         at_min_q <= rst_min;
      end else begin
         count_q  <= count_d;
         tc_q     <= tc_d;
         at_max_q <= at_max_d;
         at_min_q <= at_min_d;
      end
   end

   assign bin_count = count_q;
   assign tc        = tc_q;
   assign at_max    = at_max_q;
   assign at_min    = at_min_q;

endmodule

// File: tb/tb_cntr_ud_mod.sv
// Self-checking bench for cntr_ud_mod: directed plan plus random steps
// against a behavioural model of the counting rules.
module tb_cntr_ud_mod;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, en, up_down, sat, load;
   logic [W-1:0] load_val, max_val, bin_count;
   logic         tc, at_max, at_min;

   int n_cmp = 0;
   int n_bad = 0;

   int m_c;
   int m_tc;

   cntr_ud_mod #(.WIDTH(W), .RESET_VAL('0)) dut (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .sat(sat),
      .load(load), .load_val(load_val), .max_val(max_val),
      .bin_count(bin_count), .tc(tc), .at_max(at_max), .at_min(at_min)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Next count from the range rules, using plain integers.
   task automatic model();
      int mx;
      mx = int'(max_val);
      if (reset) begin
         m_c = 0; m_tc = 0;
      end else if (load) begin
         m_c = (int'(load_val) < mx) ? int'(load_val) : mx;
         m_tc = 0;
      end else if (en) begin
         m_tc = 0;
         if (mx == 0) begin
            m_c = 0; m_tc = 1;
         end else if (!up_down) begin
            if (m_c < mx) m_c = m_c + 1;
            else begin m_tc = 1; m_c = sat ? mx : 0; end
         end else begin
            if (m_c == 0) begin m_tc = 1; m_c = sat ? 0 : mx; end
            else m_c = (m_c > mx) ? mx : m_c - 1;
         end
      end else begin
         m_tc = 0;
      end
   endtask

   task automatic tick(input string tag);
      model();
      @(posedge clk);
      #1;
      chk({tag, "_cnt"}, 32'(bin_count), 32'(m_c));
      chk({tag, "_tc"}, 32'(tc), 32'(m_tc));
      chk({tag, "_max"}, 32'(at_max), 32'(m_c >= int'(max_val)));
      chk({tag, "_min"}, 32'(at_min), 32'(m_c == 0));
   endtask

   task automatic drv(input logic r, input logic e, input logic ud,
                      input logic s, input logic ld, input int lv,
                      input int mx);
      reset = r; en = e; up_down = ud; sat = s; load = ld;
      load_val = W'(lv); max_val = W'(mx);
   endtask

   initial begin
      m_c = 0; m_tc = 0;
      drv(1, 1, 0, 0, 0, 0, 9);
      // Reset with en high
      tick("rst0");
      tick("rst1");
      chk("rst_cnt_c", 32'(bin_count), 0);
      chk("rst_min_c", 32'(at_min), 1);
      chk("rst_max_c", 32'(at_max), 0);
      // Count up 12 steps with wrap at 9
      drv(0, 1, 0, 0, 0, 0, 9);
      for (int i = 1; i <= 12; i++) begin
         tick("up");
         chk("up_seq", 32'(bin_count), 32'(i % 10));
         chk("up_seq_tc", 32'(tc), 32'(i == 10));
      end
      // Down wrap
      drv(0, 0, 0, 0, 1, 1, 5);
      tick("dw_ld");
      drv(0, 1, 1, 0, 0, 0, 5);
      tick("dw1"); chk("dw1_c", 32'(bin_count), 0);
      tick("dw2"); chk("dw2_c", 32'(bin_count), 5);
      chk("dw2_tc", 32'(tc), 1);
      tick("dw3"); chk("dw3_c", 32'(bin_count), 4);
      // Saturate up
      drv(0, 0, 0, 1, 1, 4, 5);
      tick("sat_ld");
      drv(0, 1, 0, 1, 0, 0, 5);
      tick("su1"); chk("su1_tc", 32'(tc), 0);
      tick("su2"); chk("su2_c", 32'(bin_count), 5);
      chk("su2_tc", 32'(tc), 1);
      tick("su3"); chk("su3_tc", 32'(tc), 1);
      // Saturate down from 0
      drv(0, 0, 0, 1, 1, 0, 5);
      tick("sd_ld");
      drv(0, 1, 1, 1, 0, 0, 5);
      tick("sd1"); chk("sd1_c", 32'(bin_count), 0);
      chk("sd1_tc", 32'(tc), 1);
      // Load clamp, load over en, reset over load
      drv(0, 1, 1, 0, 1, 200, 10);
      tick("ldc"); chk("ldc_c", 32'(bin_count), 10);
      chk("ldc_tc", 32'(tc), 0);
      drv(1, 1, 0, 0, 1, 7, 10);
      tick("rl"); chk("rl_c", 32'(bin_count), 0);
      // max_val shrink, up then down
      drv(0, 0, 0, 0, 1, 8, 9);
      tick("sh_ld");
      drv(0, 1, 0, 0, 0, 0, 3);
      tick("shu"); chk("shu_c", 32'(bin_count), 0);
      chk("shu_tc", 32'(tc), 1);
      drv(0, 0, 0, 0, 1, 8, 9);
      tick("sh_ld2");
      drv(0, 1, 1, 0, 0, 0, 3);
      tick("shd"); chk("shd_c", 32'(bin_count), 3);
      chk("shd_tc", 32'(tc), 0);
      // Hold with en low while direction toggles
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, i[0], 0, 0, 0, 3);
         tick("hold");
         chk("hold_c", 32'(bin_count), 3);
      end
      // Single-value range
      for (int i = 0; i < 4; i++) begin
         drv(0, 1, i[0], i[1], 0, 0, 0);
         tick("mx0");
         chk("mx0_tc", 32'(tc), 1);
      end
      // Random traffic
      for (int i = 0; i < 400; i++) begin
         drv(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
             1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0),
             int'($urandom_range(0, 255)),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 12)));
         tick("rnd");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
